axi_irq_fetch: RTL and testbench
================================

# axi_irq_fetch

AXI master that services an interrupt controller on the SoC interconnect by draining its IRQ ID FIFO. When the controller's summary line is high, the block reads the controller's ID register and presents the returned IRQ ID to a core-side valid/ack interface. It also issues single-beat AXI writes to the controller's mask and FIFO-clear registers on request. It sits between the core's interrupt input and the interconnect, on the master side of the same AXI slave the controller exposes.

## Interface
- IRQC_BASE_ADDR, 32'h0: base address of the controller; ID register at +0x00, mask at +0x04, FIFO clear at +0x08.
- AXI_ID, 0: value driven on awid/arid.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- irq_summary_i  in  1  controller's "FIFO not empty" summary line.
- irq_vld_o  out  1  IRQ ID available to the core.
- irq_id_o  out  5  IRQ ID, 0 to 31; stable while irq_vld_o is high.
- irq_ack_i  in  1  core accepts irq_id_o.
- mask_wr_i  in  1  single-cycle pulse requesting a mask write.
- mask_i  in  32  mask value, sampled when mask_wr_i is high.
- clear_i  in  1  single-cycle pulse requesting a FIFO clear write.
- busy_o  out  1  FSM is not in IDLE, or a write request is pending.
- err_o  out  1  one-cycle pulse on a non-OKAY rresp or bresp.
- axi_mosi  out  s_axi_mosi_t  AXI master request channels (amba_axi_pkg).
- axi_miso  in  s_axi_miso_t  AXI slave response channels.

## Operation
- Reset (rst=0): state IDLE; clr_pend=0; mask_pend=0; mask_q=0; irq_id_o=0; every valid/ready output, err_o and busy_o at 0.
- All unused AXI fields are 0. Every transfer uses len=0, size=2 (4 bytes), burst=INCR, wstrb=4'hF and wlast=1.
- Request capture happens in any state:
  - clear_i sets clr_pend.
  - mask_wr_i sets mask_pend and loads mask_q.
  - A second mask_wr_i before the write issues overwrites mask_q, so only the last value is written.
- FSM states: IDLE, AR, R, DLV, WR, B.
- IDLE arbitration, highest priority first:
  1. clr_pend: go to WR with addr=BASE+0x08, wdata=0.
  2. mask_pend: go to WR with addr=BASE+0x04, wdata=mask_q.
  3. irq_summary_i=1 and holdoff=0: go to AR.
- AR: arvalid=1, araddr=BASE+0x00. Move to R on arvalid&&arready.
- R: rready=1. On rvalid, in order of precedence:
  1. rresp!=OKAY: pulse err_o, go to IDLE.
  2. rdata==32'hFFFF_FFFF (FIFO empty): drop the beat, go to IDLE.
  3. Otherwise: irq_id_o<=rdata[4:0], go to DLV.
- DLV: irq_vld_o=1. On irq_ack_i, go to IDLE. No AXI activity occurs while in DLV; pending writes wait.
- WR:
  - awvalid and wvalid assert together.
  - Each channel drops independently once its own ready is seen, so the two handshakes may land in either order or the same cycle.
  - Move to B once both handshakes are complete.
- B: bready=1. On bvalid:
  - Pulse err_o if bresp!=OKAY.
  - Clear clr_pend (address 0x08) or mask_pend (address 0x04).
  - Go to IDLE.
- Holdoff: a 1-cycle flag set on every exit from R. It masks irq_summary_i for the first IDLE cycle, because the controller's summary lags the FIFO pop by one cycle.
- A pulse of mask_wr_i or clear_i that coincides with the clearing of the same pending flag in B re-sets that flag; the new request is never lost.

## Timing
- All AXI valid/ready outputs, irq_vld_o and err_o are registered (driven from FSM state).
- With a zero-wait slave: summary seen in IDLE at cycle 0 -> arvalid at cycle 1 -> rready handshake at cycle 2 -> irq_vld_o at cycle 3.
- irq_vld_o and irq_id_o hold until ack; irq_ack_i is ignored outside DLV.
- AXI valids, once raised, stay high with stable payload until the corresponding ready.
- Back-to-back fetches are at least 1 IDLE cycle plus 1 holdoff cycle apart.
- err_o is high for exactly one cycle, the cycle after the failing response beat.
- rst asserted mid-transaction returns to reset values on the next edge. The block does not complete the outstanding AXI beat; the slave is reset by the same reset.

## Test plan
- Fetch and deliver: controller slave model returns rdata=0x0000_0007 with OKAY; irq_summary_i=1.
  -> irq_vld_o=1, irq_id_o=7 at cycle 3; drops the cycle after irq_ack_i.
- Spurious fetch: rdata=0xFFFF_FFFF.
  -> no irq_vld_o, no err_o, FSM back in IDLE; the next fetch is not attempted before holdoff expires.
- Mask write with skewed readies: mask_wr_i with mask_i=0x0000_00F0, wready 3 cycles after awready.
  -> one AW with awaddr=BASE+0x04, one W with wdata=0x0000_00F0, bready asserted; busy_o=0 after B.
- Priority: clear_i and mask_wr_i in the same cycle while irq_summary_i=1.
  -> write to +0x08 first, then +0x04, then the AR to +0x00.
- Error path: rresp=SLVERR on a read, then bresp=SLVERR on a clear.
  -> two one-cycle err_o pulses; no irq_vld_o; clr_pend cleared.
- Reset mid-DLV: rst=0 while irq_vld_o=1.
  -> next cycle irq_vld_o=0, irq_id_o=0, all AXI valids 0, busy_o=0.

Source files
------------

// File: rtl/axi_irq_fetch.sv
// AXI types shared with the interconnect, and an AXI master that drains an interrupt
// controller's ID FIFO and issues single-beat mask/clear writes to it.
package amba_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;

endpackage

// state | meaning
// IDLE  | arbitrate: pending clear, pending mask, then IRQ fetch
// AR    | read address of the ID register offered
// R     | waiting for the ID read data beat
// DLV   | IRQ ID presented to the core until acked
// WR    | write address and data offered, each dropped on its own ready
// B     | waiting for the write response
module axi_irq_fetch
  import amba_axi_pkg::*;
#(
  parameter logic [31:0] IRQC_BASE_ADDR = 32'h0,
  parameter logic [3:0]  AXI_ID         = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_summary_i,
  output logic        irq_vld_o,
  output logic [4:0]  irq_id_o,
  input  logic        irq_ack_i,
  input  logic        mask_wr_i,
  input  logic [31:0] mask_i,
  input  logic        clear_i,
  output logic        busy_o,
  output logic        err_o,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_DLV, ST_WR, ST_B} state_e;

  state_e      state_q;
  logic        clr_pend_q, mask_pend_q, wr_is_clr_q, holdoff_q;
  logic [31:0] mask_q, awaddr_q, wdata_q;
  logic [4:0]  irq_id_q;
  logic        irq_vld_q, err_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done, w_done;
  logic        unused_ok;

  assign aw_done = !awvalid_q || axi_miso.awready;
  assign w_done  = !wvalid_q || axi_miso.wready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      clr_pend_q  <= 1'b0;
      mask_pend_q <= 1'b0;
      wr_is_clr_q <= 1'b0;
      holdoff_q   <= 1'b0;
      mask_q      <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      irq_id_q    <= '0;
      irq_vld_q   <= 1'b0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      holdoff_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_pend_q) begin
            state_q     <= ST_WR;
            awaddr_q    <= IRQC_BASE_ADDR + 32'h8;
            wdata_q     <= '0;
            wr_is_clr_q <= 1'b1;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
          end else if (mask_pend_q) begin
            state_q     <= ST_WR;
            awaddr_q    <= IRQC_BASE_ADDR + 32'h4;
            wdata_q     <= mask_q;
            wr_is_clr_q <= 1'b0;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
          end else if (irq_summary_i && !holdoff_q) begin
            state_q   <= ST_AR;
            arvalid_q <= 1'b1;
          end
        end
        ST_AR: begin
          if (axi_miso.arready) begin
            state_q   <= ST_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_R: begin
          if (axi_miso.rvalid) begin
            rready_q  <= 1'b0;
            // summary lags the FIFO pop by a cycle; ignore it for one IDLE cycle
            holdoff_q <= 1'b1;
            if (axi_miso.rresp != AXI_RESP_OKAY) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (axi_miso.rdata == 32'hFFFF_FFFF) begin
              state_q <= ST_IDLE;
            end else begin
              irq_id_q  <= axi_miso.rdata[4:0];
              irq_vld_q <= 1'b1;
              state_q   <= ST_DLV;
            end
          end
        end
        ST_DLV: begin
          if (irq_ack_i) begin
            irq_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (axi_miso.awready) awvalid_q <= 1'b0;
          if (axi_miso.wready) wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            state_q  <= ST_B;
            bready_q <= 1'b1;
          end
        end
        ST_B: begin
          if (axi_miso.bvalid) begin
            bready_q <= 1'b0;
            if (axi_miso.bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            if (wr_is_clr_q) clr_pend_q <= 1'b0;
            else mask_pend_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // placed after the FSM so a request landing on its own B completion wins
      if (clear_i) clr_pend_q <= 1'b1;
      if (mask_wr_i) begin
        mask_pend_q <= 1'b1;
        mask_q      <= mask_i;
      end
    end
  end

  always_comb begin
    axi_mosi         = '0;
    axi_mosi.awid    = AXI_ID;
    axi_mosi.awaddr  = awaddr_q;
    axi_mosi.awsize  = 3'd2;
    axi_mosi.awburst = AXI_BURST_INCR;
    axi_mosi.awvalid = awvalid_q;
    axi_mosi.wdata   = wdata_q;
    axi_mosi.wstrb   = 4'hF;
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = wvalid_q;
    axi_mosi.bready  = bready_q;
    axi_mosi.arid    = AXI_ID;
    axi_mosi.araddr  = IRQC_BASE_ADDR;
    axi_mosi.arsize  = 3'd2;
    axi_mosi.arburst = AXI_BURST_INCR;
    axi_mosi.arvalid = arvalid_q;
    axi_mosi.rready  = rready_q;
  end

  assign irq_vld_o = irq_vld_q;
  assign irq_id_o  = irq_id_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_IDLE) || clr_pend_q || mask_pend_q;
  assign unused_ok = ^{axi_miso.bid, axi_miso.rid, axi_miso.rlast};

endmodule

// File: tb/tb_axi_irq_fetch.sv
// Bench for axi_irq_fetch: AXI slave model with write/IRQ scoreboards, a table of
// read responses, and hand-written sequences for timing, priority and reset.
module tb_axi_irq_fetch;
  import amba_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        irq_summary_i = 1'b0, irq_ack_i = 1'b0, mask_wr_i = 1'b0, clear_i = 1'b0;
  logic [31:0] mask_i = '0;
  logic        irq_vld_o, busy_o, err_o;
  logic [4:0]  irq_id_o;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso = '0;

  always #5 clk = ~clk;

  axi_irq_fetch #(.IRQC_BASE_ADDR(BASE), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst(rst), .irq_summary_i(irq_summary_i), .irq_vld_o(irq_vld_o),
    .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i), .mask_wr_i(mask_wr_i), .mask_i(mask_i),
    .clear_i(clear_i), .busy_o(busy_o), .err_o(err_o), .axi_mosi(mosi), .axi_miso(miso)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [31:0] rdata; logic [1:0] rresp; logic exp_vld; logic [4:0] exp_id; logic exp_err;
  } vec_t;

  wr_t         exp_wr[$];
  logic [4:0]  exp_irq[$];
  logic [31:0] order_q[$];

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic pop_irq();
    if (exp_irq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL irq_unexpected actual_id=%0d", irq_id_o);
    end else chk("irq_id", {27'b0, irq_id_o}, {27'b0, exp_irq.pop_front()});
  endtask

  logic [31:0] rdata_cfg = '0;
  logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;
  int          aw_lat = 0, w_lat = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, err_cnt = 0;

  // slave model: observe handshakes at negedge, drive responses just after posedge
  initial begin
    logic r_pend, b_pend, aw_got, w_got, aw_hs, w_hs, nxt_aw, nxt_w;
    logic [31:0] aw_addr, w_data;
    int aw_wait, w_wait;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
    aw_addr = '0; w_data = '0;
    forever begin
      @(negedge clk);
      aw_hs = mosi.awvalid && miso.awready;
      w_hs  = mosi.wvalid && miso.wready;
      if (!rst) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (mosi.arvalid && miso.arready) begin
          ar_cnt++;
          order_q.push_back(mosi.araddr);
          chk("ar_addr", mosi.araddr, BASE);
          chk("ar_attr", {15'b0, mosi.arid, mosi.arlen, mosi.arsize, mosi.arburst},
              {15'b0, 4'h0, 8'h0, 3'd2, 2'b01});
          r_pend = 1;
        end
        if (miso.rvalid && mosi.rready) begin r_cnt++; r_pend = 0; end
        if (aw_hs) begin
          aw_cnt++;
          order_q.push_back(mosi.awaddr);
          aw_addr = mosi.awaddr;
          aw_got = 1;
          aw_wait = 0;
          chk("aw_attr", {15'b0, mosi.awid, mosi.awlen, mosi.awsize, mosi.awburst},
              {15'b0, 4'h0, 8'h0, 3'd2, 2'b01});
        end else if (mosi.awvalid) aw_wait++;
        if (w_hs) begin
          w_cnt++;
          w_data = mosi.wdata;
          w_got = 1;
          w_wait = 0;
          chk("w_strb_last", {27'b0, mosi.wstrb, mosi.wlast}, {27'b0, 4'hF, 1'b1});
        end else if (mosi.wvalid) w_wait++;
        if (miso.bvalid && mosi.bready) begin b_cnt++; b_pend = 0; end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1;
          if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected addr=0x%08h data=0x%08h", aw_addr, w_data);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", aw_addr, e.addr);
            chk("wr_data", w_data, e.data);
          end
        end
      end
      nxt_aw = (aw_lat == 0) || (mosi.awvalid && !aw_hs && aw_wait >= aw_lat);
      nxt_w  = (w_lat == 0) || (mosi.wvalid && !w_hs && w_wait >= w_lat);
      @(posedge clk);
      #1;
      miso.arready = 1'b1;
      miso.rvalid  = r_pend;
      miso.rdata   = r_pend ? rdata_cfg : 32'h0;
      miso.rresp   = r_pend ? rresp_cfg : 2'b00;
      miso.rlast   = r_pend;
      miso.bvalid  = b_pend;
      miso.bresp   = b_pend ? bresp_cfg : 2'b00;
      miso.awready = nxt_aw;
      miso.wready  = nxt_w;
    end
  end

  // err_o must be a single-cycle pulse; irq_id_o must hold while irq_vld_o is high
  initial begin
    logic err_prev, vld_prev;
    logic [4:0] id_prev;
    err_prev = 0; vld_prev = 0; id_prev = '0;
    forever begin
      @(negedge clk);
      if (err_o) begin
        err_cnt++;
        chk("err_width", {31'b0, err_prev}, 32'h0);
      end
      if (irq_vld_o && vld_prev) chk("id_stable", {27'b0, irq_id_o}, {27'b0, id_prev});
      err_prev = err_o;
      vld_prev = irq_vld_o;
      id_prev  = irq_id_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time_limit_reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  vec_t tv[8];

  initial begin
    int e0, b0, a0, w0, r0;
    tv[0] = '{32'h0000_0007, 2'b00, 1'b1, 5'd7,  1'b0};
    tv[1] = '{32'hFFFF_FFFF, 2'b00, 1'b0, 5'd0,  1'b0};
    tv[2] = '{32'h0000_001F, 2'b00, 1'b1, 5'd31, 1'b0};
    tv[3] = '{32'h0000_0000, 2'b00, 1'b1, 5'd0,  1'b0};
    tv[4] = '{32'hABCD_0025, 2'b00, 1'b1, 5'd5,  1'b0};
    tv[5] = '{32'h0000_0003, 2'b10, 1'b0, 5'd0,  1'b1};
    tv[6] = '{32'hFFFF_FFFF, 2'b11, 1'b0, 5'd0,  1'b1};
    tv[7] = '{32'hFFFF_FFFE, 2'b00, 1'b1, 5'd30, 1'b0};

    repeat (3) tick();
    chk("rst_vld", {31'b0, irq_vld_o}, 0);
    chk("rst_id", {27'b0, irq_id_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    chk("rst_valids", {27'b0, mosi.arvalid, mosi.awvalid, mosi.wvalid, mosi.rready, mosi.bready}, 0);
    rst = 1'b1;
    tick();

    // fetch and deliver, cycle-exact against a zero-wait slave
    rdata_cfg = 32'h7;
    exp_irq.push_back(5'd7);
    irq_summary_i = 1'b1;
    tick();
    chk("t1_arvalid", {31'b0, mosi.arvalid}, 1);
    tick();
    chk("t1_rready", {31'b0, mosi.rready}, 1);
    tick();
    chk("t1_vld_c3", {31'b0, irq_vld_o}, 1);
    pop_irq();
    irq_summary_i = 1'b0;
    tick();
    chk("t1_vld_hold", {31'b0, irq_vld_o}, 1);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    chk("t1_vld_drop", {31'b0, irq_vld_o}, 0);
    tick();
    chk("t1_busy", {31'b0, busy_o}, 0);

    // spurious read and holdoff spacing with summary held high
    e0 = err_cnt;
    rdata_cfg = 32'hFFFF_FFFF;
    irq_summary_i = 1'b1;
    tick();
    chk("ho_ar1", {31'b0, mosi.arvalid}, 1);
    tick();
    tick();
    chk("ho_idle_c3", {30'b0, mosi.arvalid, irq_vld_o}, 0);
    tick();
    chk("ho_idle_c4", {31'b0, mosi.arvalid}, 0);
    tick();
    chk("ho_ar2_c5", {31'b0, mosi.arvalid}, 1);
    irq_summary_i = 1'b0;
    r0 = r_cnt;
    for (int n = 0; n < 20 && r_cnt == r0; n++) tick();
    chk("ho_r_to", {31'b0, r_cnt != r0}, 1);
    repeat (2) tick();
    chk("ho_vld", {31'b0, irq_vld_o}, 0);
    chk("ho_busy", {31'b0, busy_o}, 0);
    chk("ho_err", err_cnt - e0, 0);

    // table of read responses
    for (int i = 0; i < 8; i++) begin
      rdata_cfg = tv[i].rdata;
      rresp_cfg = tv[i].rresp;
      if (tv[i].exp_vld) exp_irq.push_back(tv[i].exp_id);
      e0 = err_cnt;
      r0 = r_cnt;
      irq_summary_i = 1'b1;
      for (int n = 0; n < 20 && r_cnt == r0; n++) tick();
      irq_summary_i = 1'b0;
      chk("tv_r_to", {31'b0, r_cnt != r0}, 1);
      chk("tv_vld", {31'b0, irq_vld_o}, {31'b0, tv[i].exp_vld});
      chk("tv_err", {31'b0, err_o}, {31'b0, tv[i].exp_err});
      if (irq_vld_o) begin
        pop_irq();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
      end
      repeat (2) tick();
      chk("tv_busy", {31'b0, busy_o}, 0);
      chk("tv_err_cnt", err_cnt - e0, {31'b0, tv[i].exp_err});
    end
    rresp_cfg = 2'b00;

    // mask write, wready three cycles after awready
    w_lat = 3;
    push_wr(BASE + 32'h4, 32'h0000_00F0);
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    mask_i = 32'h0000_00F0;
    mask_wr_i = 1'b1;
    tick();
    mask_wr_i = 1'b0;
    chk("mw_busy_pend", {31'b0, busy_o}, 1);
    for (int n = 0; n < 10 && !mosi.awvalid; n++) tick();
    chk("mw_aw_to", {31'b0, mosi.awvalid}, 1);
    tick();
    chk("mw_skew", {30'b0, mosi.awvalid, mosi.wvalid}, 32'h1);
    for (int n = 0; n < 40 && b_cnt == b0; n++) tick();
    chk("mw_b_to", {31'b0, b_cnt != b0}, 1);
    tick();
    chk("mw_busy_done", {31'b0, busy_o}, 0);
    chk("mw_aw_n", aw_cnt - a0, 1);
    chk("mw_w_n", w_cnt - w0, 1);
    w_lat = 0;

    // priority: clear, then last mask value, then the fetch
    rdata_cfg = 32'h2;
    exp_irq.push_back(5'd2);
    irq_summary_i = 1'b1;
    for (int n = 0; n < 20 && !irq_vld_o; n++) tick();
    chk("pr_vld1", {31'b0, irq_vld_o}, 1);
    pop_irq();
    order_q.delete();
    push_wr(BASE + 32'h8, 32'h0);
    push_wr(BASE + 32'h4, 32'h0000_00F0);
    clear_i = 1'b1; mask_wr_i = 1'b1; mask_i = 32'h11;
    tick();
    clear_i = 1'b0; mask_i = 32'h0000_00F0;
    tick();
    mask_wr_i = 1'b0;
    rdata_cfg = 32'h9;
    exp_irq.push_back(5'd9);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    for (int n = 0; n < 40 && !irq_vld_o; n++) tick();
    chk("pr_vld2", {31'b0, irq_vld_o}, 1);
    pop_irq();
    irq_summary_i = 1'b0;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    chk("pr_n", order_q.size(), 3);
    if (order_q.size() == 3) begin
      chk("pr_first", order_q[0], BASE + 32'h8);
      chk("pr_second", order_q[1], BASE + 32'h4);
      chk("pr_third", order_q[2], BASE);
    end
    repeat (3) tick();
    chk("pr_busy", {31'b0, busy_o}, 0);

    // clear request landing on the completing clear's B beat is kept
    push_wr(BASE + 32'h8, 32'h0);
    push_wr(BASE + 32'h8, 32'h0);
    b0 = b_cnt;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int n = 0; n < 20 && !mosi.bready; n++) tick();
    chk("co_bready", {31'b0, mosi.bready}, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int n = 0; n < 40 && b_cnt - b0 < 2; n++) tick();
    chk("co_b_n", b_cnt - b0, 2);
    tick();
    chk("co_busy", {31'b0, busy_o}, 0);

    // bresp error on a clear
    bresp_cfg = 2'b10;
    push_wr(BASE + 32'h8, 32'h0);
    e0 = err_cnt; b0 = b_cnt;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int n = 0; n < 40 && b_cnt == b0; n++) tick();
    chk("be_err_hi", {31'b0, err_o}, 1);
    tick();
    chk("be_err_lo", {31'b0, err_o}, 0);
    chk("be_busy", {31'b0, busy_o}, 0);
    chk("be_err_n", err_cnt - e0, 1);
    chk("be_vld", {31'b0, irq_vld_o}, 0);
    bresp_cfg = 2'b00;

    // reset while delivering; a mask request in the reset cycle is dropped too
    rdata_cfg = 32'h15;
    irq_summary_i = 1'b1;
    for (int n = 0; n < 20 && !irq_vld_o; n++) tick();
    irq_summary_i = 1'b0;
    chk("rd_id", {27'b0, irq_id_o}, 32'h15);
    rst = 1'b0;
    mask_wr_i = 1'b1; mask_i = 32'hAA;
    tick();
    rst = 1'b1;
    mask_wr_i = 1'b0;
    chk("rd_vld", {31'b0, irq_vld_o}, 0);
    chk("rd_id0", {27'b0, irq_id_o}, 0);
    chk("rd_valids", {27'b0, mosi.arvalid, mosi.awvalid, mosi.wvalid, mosi.rready, mosi.bready}, 0);
    chk("rd_busy", {31'b0, busy_o}, 0);
    a0 = aw_cnt;
    repeat (5) tick();
    chk("rd_no_wr", aw_cnt - a0, 0);
    chk("rd_busy2", {31'b0, busy_o}, 0);

    chk("left_wr", exp_wr.size(), 0);
    chk("left_irq", exp_irq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
